// File: rtl/udp_recv_pkg.sv
// Shared constants for the UDP receive path: FSM encoding, header word layout
// and the info-word flag position.
package udp_recv_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HEADER    = 4'd1;
  localparam logic [3:0] S_INFO      = 4'd2;
  localparam logic [3:0] S_PAYLOAD   = 4'd3;
  localparam logic [3:0] S_TAIL      = 4'd4;
  localparam logic [3:0] S_DROP      = 4'd5;
  localparam logic [3:0] S_KICK      = 4'd6;
  localparam logic [3:0] S_WAIT_BUSY = 4'd7;
  localparam logic [3:0] S_WAIT_DONE = 4'd8;

  localparam logic [1:0] HDR_SRC_IP = 2'd0;
  localparam logic [1:0] HDR_DST_IP = 2'd1;
  localparam logic [1:0] HDR_PORTS  = 2'd2;
  localparam logic [1:0] HDR_LEN    = 2'd3;

  localparam int INFO_LAST_BIT = 31;
  localparam int WAIT_TIMEOUT  = 16;

  // Payload words = total words minus the info word; underflows for length < 4.
  function automatic logic [31:0] len_to_words(input logic [31:0] len);
    return (len >> 2) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo32.sv
// 32-bit synchronous FIFO with registered read data and a synchronous flush.
module sync_fifo32 #(
  parameter int BUF_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [31:0]       din,
  input  logic              pop,
  output logic [31:0]       dout,
  output logic              full,
  output logic              empty,
  output logic [BUF_AW:0]   count
);

  localparam logic [BUF_AW:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};

  logic [31:0]       mem [0:(1<<BUF_AW)-1];
  logic [BUF_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUF_AW:0]   count_q;
  logic [31:0]       dout_q;
  logic              do_push, do_pop;

  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = dout_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage array has no reset; the pointers alone define what is valid,
  // and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem[rd_ptr_q];
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/udp_recv.sv
// UDP packet receiver: parses the header, buffers the payload, then hands the
// buffered words to a DRAM writer via a kick/busy handshake.
module udp_recv
  import udp_recv_pkg::*;
#(
  parameter int          MAX_WORDS  = 64,
  parameter logic [15:0] LOCAL_PORT = 16'h4000,
  parameter int          BUF_AW     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_req,
  output logic        r_ack,
  input  logic        r_enable,
  input  logic [31:0] r_data,
  output logic        kick,
  input  logic        busy,
  output logic [31:0] write_num,
  output logic [31:0] write_addr,
  input  logic        buf_re,
  output logic [31:0] buf_dout,
  output logic        frame_done,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  logic [3:0]  state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [31:0] nwords_q, nwords_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] write_addr_q, write_addr_d;
  logic [31:0] write_num_q, write_num_d;
  logic        last_q, last_d;
  logic        kick_q, kick_d;
  logic        frame_done_q, frame_done_d;
  logic        r_ack_q;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [3:0]  tmo_q, tmo_d;

  logic          fifo_push, fifo_flush, buf_full, buf_empty;
  logic [BUF_AW:0] buf_count;
  logic [31:0]   nwords_w;
  logic          hdr_ok;

  sync_fifo32 #(.BUF_AW(BUF_AW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push && !buf_full),
    .din   (r_data),
    .pop   (buf_re),
    .dout  (buf_dout),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign nwords_w = len_to_words(r_data);
  assign hdr_ok   = (dst_port_q == LOCAL_PORT) && (r_data[1:0] == 2'b00) &&
                    (r_data >= 32'd8) && (nwords_w <= 32'(MAX_WORDS));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    dst_port_d   = dst_port_q;
    nwords_d     = nwords_q;
    cnt_d        = cnt_q;
    write_addr_d = write_addr_q;
    write_num_d  = write_num_q;
    last_d       = last_q;
    kick_d       = 1'b0;
    frame_done_d = 1'b0;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    tmo_d        = tmo_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;

    unique case (state_q)
      S_IDLE: if (r_enable) begin
        hdr_cnt_d = HDR_DST_IP;
        state_d   = S_HEADER;
      end
      S_HEADER: if (r_enable) begin
        hdr_cnt_d = hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == HDR_PORTS) dst_port_d = r_data[15:0];
        if (hdr_cnt_q == HDR_LEN) begin
          nwords_d = nwords_w;
          state_d  = hdr_ok ? S_INFO : S_DROP;
        end
      end
      S_INFO: if (r_enable) begin
        write_addr_d = {1'b0, r_data[30:0]};
        last_d       = r_data[INFO_LAST_BIT];
        cnt_d        = '0;
        state_d      = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // Sender gave up early: discard what was buffered.
        if (!r_req) begin
          fifo_flush   = 1'b1;
          drop_count_d = drop_count_q + 16'd1;
          state_d      = S_IDLE;
        end else if (r_enable) begin
          fifo_push = 1'b1;
          cnt_d     = cnt_q + 32'd1;
          if (cnt_q == nwords_q - 32'd1) state_d = S_TAIL;
        end
      end
      S_TAIL: if (!r_enable) begin
        pkt_count_d = pkt_count_q + 16'd1;
        state_d     = S_KICK;
      end
      S_DROP: if (!r_enable) begin
        drop_count_d = drop_count_q + 16'd1;
        state_d      = S_IDLE;
      end
      S_KICK: if (!busy) begin
        write_num_d = nwords_q;
        kick_d      = 1'b1;
        tmo_d       = '0;
        state_d     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy || tmo_q == 4'(WAIT_TIMEOUT - 1)) state_d = S_WAIT_DONE;
        else tmo_d = tmo_q + 4'd1;
      end
      S_WAIT_DONE: if (!busy && buf_empty) begin
        frame_done_d = last_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hdr_cnt_q    <= HDR_SRC_IP;
      dst_port_q   <= '0;
      nwords_q     <= '0;
      cnt_q        <= '0;
      write_addr_q <= '0;
      write_num_q  <= '0;
      last_q       <= 1'b0;
      kick_q       <= 1'b0;
      frame_done_q <= 1'b0;
      r_ack_q      <= 1'b0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      dst_port_q   <= dst_port_d;
      nwords_q     <= nwords_d;
      cnt_q        <= cnt_d;
      write_addr_q <= write_addr_d;
      write_num_q  <= write_num_d;
      last_q       <= last_d;
      kick_q       <= kick_d;
      frame_done_q <= frame_done_d;
      r_ack_q      <= (state_q == S_IDLE) && (buf_count == '0) && !busy;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      tmo_q        <= tmo_d;
    end
  end

  assign r_ack      = r_ack_q;
  assign kick       = kick_q;
  assign write_num  = write_num_q;
  assign write_addr = write_addr_q;
  assign frame_done = frame_done_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule
